// File: rtl/dlx_pkg.sv
// Shared types and encodings for the DLX multicycle control unit: ALU
// operations, FSM states, instruction classes and opcode/func values.
package dlx_pkg;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL
    } aluOp;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_J,
        CLS_JAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_NOP   = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [10:0] FN_SLL = 11'h004;
    localparam logic [10:0] FN_SRL = 11'h006;
    localparam logic [10:0] FN_ADD = 11'h020;
    localparam logic [10:0] FN_SUB = 11'h022;
    localparam logic [10:0] FN_AND = 11'h024;
    localparam logic [10:0] FN_OR  = 11'h025;
    localparam logic [10:0] FN_XOR = 11'h026;

endpackage

// File: rtl/dlx_mc_decode.sv
// Combinational instruction decoder: opcode/func to instruction class,
// ALU operation, operand-B select and an illegal-instruction flag.
module dlx_mc_decode
    import dlx_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [10:0]  func,
    output instr_class_t cls,
    output aluOp         alu_op,
    output logic         muxb_sel,
    output logic         illegal
);

    always_comb begin
        cls      = CLS_NOP;
        alu_op   = ALU_NOP;
        muxb_sel = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls = CLS_ALU;
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin cls = CLS_ALU; alu_op = ALU_ADD; muxb_sel = 1'b1; end
            OP_SUBI: begin cls = CLS_ALU; alu_op = ALU_SUB; muxb_sel = 1'b1; end
            OP_ANDI: begin cls = CLS_ALU; alu_op = ALU_AND; muxb_sel = 1'b1; end
            OP_ORI:  begin cls = CLS_ALU; alu_op = ALU_OR;  muxb_sel = 1'b1; end
            OP_XORI: begin cls = CLS_ALU; alu_op = ALU_XOR; muxb_sel = 1'b1; end
            // Address and target computations are all base + IMM.
            OP_LW:   begin cls = CLS_LW;  alu_op = ALU_ADD; muxb_sel = 1'b1; end
            OP_SW:   begin cls = CLS_SW;  alu_op = ALU_ADD; muxb_sel = 1'b1; end
            OP_BEQZ,
            OP_BNEZ: begin cls = CLS_BR;  alu_op = ALU_ADD; muxb_sel = 1'b1; end
            OP_J:    begin cls = CLS_J;   alu_op = ALU_ADD; muxb_sel = 1'b1; end
            OP_JAL:  begin cls = CLS_JAL; alu_op = ALU_ADD; muxb_sel = 1'b1; end
            OP_NOP:  cls = CLS_NOP;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dlx_mc_ctrl.sv
// Multicycle hardwired control FSM for the DLX core: sequences
// FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module dlx_mc_ctrl
    import dlx_pkg::*;
#(
    parameter int IR_SIZE = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IR_SIZE-1:0] IR_IN,
    input  logic               DRAM_RDY,
    output logic               IR_LATCH_EN,
    output logic               NPC_LATCH_EN,
    output logic               RegA_LATCH_EN,
    output logic               RegB_LATCH_EN,
    output logic               RegIMM_LATCH_EN,
    output logic               MUXA_SEL,
    output logic               MUXB_SEL,
    output aluOp               ALU_OPCODE,
    output logic               ALU_OUTREG_EN,
    output logic               EQ_COND,
    output logic               JUMP_EN,
    output logic               PC_LATCH_EN,
    output logic               DRAM_REQ,
    output logic               DRAM_WE,
    output logic               LMD_LATCH_EN,
    output logic               WB_MUX_SEL,
    output logic               RF_WE,
    output logic               JAL_SEL,
    output logic               HALTED,
    output logic [CNT_W-1:0]   INSTR_CNT
);

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [5:0]   opcode;
    logic [10:0]  func;
    instr_class_t cls;
    aluOp         dec_alu_op;
    logic         dec_muxb_sel;
    logic         dec_illegal;
    logic         unused_ir;

    assign opcode    = IR_IN[IR_SIZE-1 -: 6];
    assign func      = IR_IN[10:0];
    assign unused_ir = ^IR_IN[IR_SIZE-7:11];

    dlx_mc_decode u_decode (
        .opcode   (opcode),
        .func     (func),
        .cls      (cls),
        .alu_op   (dec_alu_op),
        .muxb_sel (dec_muxb_sel),
        .illegal  (dec_illegal)
    );

    always_comb begin
        // NOTE: every output and next-state gets a default before the case so
        // no path leaves a variable unassigned, which would infer a latch.
        state_d         = state_q;
        IR_LATCH_EN     = 1'b0;
        NPC_LATCH_EN    = 1'b0;
        RegA_LATCH_EN   = 1'b0;
        RegB_LATCH_EN   = 1'b0;
        RegIMM_LATCH_EN = 1'b0;
        MUXA_SEL        = 1'b0;
        MUXB_SEL        = 1'b0;
        ALU_OPCODE      = ALU_NOP;
        ALU_OUTREG_EN   = 1'b0;
        EQ_COND         = 1'b0;
        JUMP_EN         = 1'b0;
        PC_LATCH_EN     = 1'b0;
        DRAM_REQ        = 1'b0;
        DRAM_WE         = 1'b0;
        LMD_LATCH_EN    = 1'b0;
        WB_MUX_SEL      = 1'b0;
        RF_WE           = 1'b0;
        JAL_SEL         = 1'b0;
        HALTED          = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                IR_LATCH_EN  = 1'b1;
                NPC_LATCH_EN = 1'b1;
                state_d      = ST_DECODE;
            end
            ST_DECODE: begin
                RegA_LATCH_EN   = 1'b1;
                RegB_LATCH_EN   = 1'b1;
                RegIMM_LATCH_EN = 1'b1;
                state_d         = dec_illegal ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                MUXA_SEL      = (cls == CLS_ALU) || (cls == CLS_LW) || (cls == CLS_SW);
                MUXB_SEL      = dec_muxb_sel;
                ALU_OPCODE    = dec_alu_op;
                ALU_OUTREG_EN = 1'b1;
                case (cls)
                    CLS_BR: begin
                        JUMP_EN     = 1'b1;
                        EQ_COND     = (opcode == OP_BEQZ);
                        PC_LATCH_EN = 1'b1;
                        state_d     = ST_FETCH;
                    end
                    CLS_J: begin
                        JUMP_EN     = 1'b1;
                        EQ_COND     = 1'b1;
                        PC_LATCH_EN = 1'b1;
                        state_d     = ST_FETCH;
                    end
                    CLS_JAL: begin
                        JUMP_EN = 1'b1;
                        EQ_COND = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    CLS_ALU:        state_d = ST_WB;
                    default: begin
                        PC_LATCH_EN = 1'b1;
                        state_d     = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                // Request and strobe are held every wait cycle until the acknowledge.
                DRAM_REQ     = 1'b1;
                DRAM_WE      = (cls == CLS_SW);
                LMD_LATCH_EN = (cls == CLS_LW) && DRAM_RDY;
                if (DRAM_RDY) begin
                    if (cls == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        PC_LATCH_EN = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                RF_WE       = 1'b1;
                WB_MUX_SEL  = (cls == CLS_LW);
                JAL_SEL     = (cls == CLS_JAL);
                PC_LATCH_EN = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_HALT: HALTED = 1'b1;
            default: state_d = ST_RST;
        endcase

        cnt_d = PC_LATCH_EN ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_dlx_mc_ctrl.sv
// Table-driven bench for dlx_mc_ctrl: per-cycle expected output vectors
// for each instruction type, plus halt, mid-MEM reset and counter wrap.
module tb_dlx_mc_ctrl;
    import dlx_pkg::*;

    localparam logic [17:0] B_IR   = 18'h20000;
    localparam logic [17:0] B_NPC  = 18'h10000;
    localparam logic [17:0] B_RA   = 18'h08000;
    localparam logic [17:0] B_RB   = 18'h04000;
    localparam logic [17:0] B_RI   = 18'h02000;
    localparam logic [17:0] B_MA   = 18'h01000;
    localparam logic [17:0] B_MB   = 18'h00800;
    localparam logic [17:0] B_OUT  = 18'h00400;
    localparam logic [17:0] B_EQ   = 18'h00200;
    localparam logic [17:0] B_JMP  = 18'h00100;
    localparam logic [17:0] B_PC   = 18'h00080;
    localparam logic [17:0] B_REQ  = 18'h00040;
    localparam logic [17:0] B_WE   = 18'h00020;
    localparam logic [17:0] B_LMD  = 18'h00010;
    localparam logic [17:0] B_WBM  = 18'h00008;
    localparam logic [17:0] B_RFWE = 18'h00004;
    localparam logic [17:0] B_JAL  = 18'h00002;
    localparam logic [17:0] B_HALT = 18'h00001;
    localparam logic [17:0] F      = B_IR | B_NPC;
    localparam logic [17:0] D      = B_RA | B_RB | B_RI;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_BEQZ = 32'h10200008;
    localparam logic [31:0] I_BNEZ = 32'h14200008;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_XORI = 32'h38220003;
    localparam logic [31:0] I_SRL  = 32'h00221806;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_NOP  = 32'h54000000;
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_BADF = 32'h00221821;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        rdy;
        logic [17:0] en;
        aluOp        alu;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir_in;
    logic        dram_rdy;
    logic        ir_latch_en, npc_latch_en, rega_latch_en, regb_latch_en, regimm_latch_en;
    logic        muxa_sel, muxb_sel, alu_outreg_en, eq_cond, jump_en, pc_latch_en;
    logic        dram_req, dram_we, lmd_latch_en, wb_mux_sel, rf_we, jal_sel, halted;
    aluOp        alu_opcode;
    logic [3:0]  instr_cnt;
    logic [17:0] en_act;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_cnt = 4'd0;
    vec_t        tbl[$];

    dlx_mc_ctrl #(.IR_SIZE(32), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst_n),
        .IR_IN           (ir_in),
        .DRAM_RDY        (dram_rdy),
        .IR_LATCH_EN     (ir_latch_en),
        .NPC_LATCH_EN    (npc_latch_en),
        .RegA_LATCH_EN   (rega_latch_en),
        .RegB_LATCH_EN   (regb_latch_en),
        .RegIMM_LATCH_EN (regimm_latch_en),
        .MUXA_SEL        (muxa_sel),
        .MUXB_SEL        (muxb_sel),
        .ALU_OPCODE      (alu_opcode),
        .ALU_OUTREG_EN   (alu_outreg_en),
        .EQ_COND         (eq_cond),
        .JUMP_EN         (jump_en),
        .PC_LATCH_EN     (pc_latch_en),
        .DRAM_REQ        (dram_req),
        .DRAM_WE         (dram_we),
        .LMD_LATCH_EN    (lmd_latch_en),
        .WB_MUX_SEL      (wb_mux_sel),
        .RF_WE           (rf_we),
        .JAL_SEL         (jal_sel),
        .HALTED          (halted),
        .INSTR_CNT       (instr_cnt)
    );

    assign en_act = {ir_latch_en, npc_latch_en, rega_latch_en, regb_latch_en, regimm_latch_en,
                     muxa_sel, muxb_sel, alu_outreg_en, eq_cond, jump_en, pc_latch_en,
                     dram_req, dram_we, lmd_latch_en, wb_mux_sel, rf_we, jal_sel, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] ir, input logic rdy,
                                input logic [17:0] en, input aluOp alu);
        vec_t v;
        v.name = n;
        v.ir   = ir;
        v.rdy  = rdy;
        v.en   = en;
        v.alu  = alu;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, check on the falling edge.
    task automatic run_row(input vec_t v);
        @(posedge clk);
        #1;
        ir_in    = v.ir;
        dram_rdy = v.rdy;
        @(negedge clk);
        check({v.name, "_en"},  32'(en_act),     32'(v.en));
        check({v.name, "_alu"}, 32'(alu_opcode), 32'(v.alu));
        check({v.name, "_cnt"}, 32'(instr_cnt),  32'(exp_cnt));
        if (v.en[7]) exp_cnt = exp_cnt + 4'd1;
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check({name, "_en"},  32'(en_act),     32'd0);
        check({name, "_alu"}, 32'(alu_opcode), 32'(ALU_NOP));
        check({name, "_cnt"}, 32'(instr_cnt),  32'd0);
        exp_cnt = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ir_in    = 32'd0;
        dram_rdy = 1'b0;

        tbl.push_back(mk("add_f",   I_ADD,  1'b0, F, ALU_NOP));
        tbl.push_back(mk("add_d",   I_ADD,  1'b1, D, ALU_NOP));
        tbl.push_back(mk("add_e",   I_ADD,  1'b1, B_MA | B_OUT, ALU_ADD));
        tbl.push_back(mk("add_wb",  I_ADD,  1'b1, B_RFWE | B_PC, ALU_NOP));
        tbl.push_back(mk("lw_f",    I_LW,   1'b1, F, ALU_NOP));
        tbl.push_back(mk("lw_d",    I_LW,   1'b1, D, ALU_NOP));
        tbl.push_back(mk("lw_e",    I_LW,   1'b1, B_MA | B_MB | B_OUT, ALU_ADD));
        tbl.push_back(mk("lw_m0",   I_LW,   1'b0, B_REQ, ALU_NOP));
        tbl.push_back(mk("lw_m1",   I_LW,   1'b0, B_REQ, ALU_NOP));
        tbl.push_back(mk("lw_m2",   I_LW,   1'b0, B_REQ, ALU_NOP));
        tbl.push_back(mk("lw_m3",   I_LW,   1'b1, B_REQ | B_LMD, ALU_NOP));
        tbl.push_back(mk("lw_wb",   I_LW,   1'b0, B_WBM | B_RFWE | B_PC, ALU_NOP));
        tbl.push_back(mk("beqz_f",  I_BEQZ, 1'b0, F, ALU_NOP));
        tbl.push_back(mk("beqz_d",  I_BEQZ, 1'b0, D, ALU_NOP));
        tbl.push_back(mk("beqz_e",  I_BEQZ, 1'b1, B_MB | B_OUT | B_EQ | B_JMP | B_PC, ALU_ADD));
        tbl.push_back(mk("bnez_f",  I_BNEZ, 1'b0, F, ALU_NOP));
        tbl.push_back(mk("bnez_d",  I_BNEZ, 1'b0, D, ALU_NOP));
        tbl.push_back(mk("bnez_e",  I_BNEZ, 1'b0, B_MB | B_OUT | B_JMP | B_PC, ALU_ADD));
        tbl.push_back(mk("jal_f",   I_JAL,  1'b1, F, ALU_NOP));
        tbl.push_back(mk("jal_d",   I_JAL,  1'b1, D, ALU_NOP));
        tbl.push_back(mk("jal_e",   I_JAL,  1'b1, B_MB | B_OUT | B_EQ | B_JMP, ALU_ADD));
        tbl.push_back(mk("jal_wb",  I_JAL,  1'b1, B_RFWE | B_JAL | B_PC, ALU_NOP));
        tbl.push_back(mk("sw_f",    I_SW,   1'b1, F, ALU_NOP));
        tbl.push_back(mk("sw_d",    I_SW,   1'b1, D, ALU_NOP));
        tbl.push_back(mk("sw_e",    I_SW,   1'b1, B_MA | B_MB | B_OUT, ALU_ADD));
        tbl.push_back(mk("sw_m",    I_SW,   1'b1, B_REQ | B_WE | B_PC, ALU_NOP));
        tbl.push_back(mk("addi_f",  I_ADDI, 1'b0, F, ALU_NOP));
        tbl.push_back(mk("addi_d",  I_ADDI, 1'b0, D, ALU_NOP));
        tbl.push_back(mk("addi_e",  I_ADDI, 1'b0, B_MA | B_MB | B_OUT, ALU_ADD));
        tbl.push_back(mk("addi_wb", I_ADDI, 1'b0, B_RFWE | B_PC, ALU_NOP));
        tbl.push_back(mk("sub_f",   I_SUB,  1'b0, F, ALU_NOP));
        tbl.push_back(mk("sub_d",   I_SUB,  1'b0, D, ALU_NOP));
        tbl.push_back(mk("sub_e",   I_SUB,  1'b0, B_MA | B_OUT, ALU_SUB));
        tbl.push_back(mk("sub_wb",  I_SUB,  1'b0, B_RFWE | B_PC, ALU_NOP));
        tbl.push_back(mk("xori_f",  I_XORI, 1'b0, F, ALU_NOP));
        tbl.push_back(mk("xori_d",  I_XORI, 1'b0, D, ALU_NOP));
        tbl.push_back(mk("xori_e",  I_XORI, 1'b0, B_MA | B_MB | B_OUT, ALU_XOR));
        tbl.push_back(mk("xori_wb", I_XORI, 1'b0, B_RFWE | B_PC, ALU_NOP));
        tbl.push_back(mk("srl_f",   I_SRL,  1'b0, F, ALU_NOP));
        tbl.push_back(mk("srl_d",   I_SRL,  1'b0, D, ALU_NOP));
        tbl.push_back(mk("srl_e",   I_SRL,  1'b0, B_MA | B_OUT, ALU_SRL));
        tbl.push_back(mk("srl_wb",  I_SRL,  1'b0, B_RFWE | B_PC, ALU_NOP));
        tbl.push_back(mk("j_f",     I_J,    1'b0, F, ALU_NOP));
        tbl.push_back(mk("j_d",     I_J,    1'b0, D, ALU_NOP));
        tbl.push_back(mk("j_e",     I_J,    1'b0, B_MB | B_OUT | B_EQ | B_JMP | B_PC, ALU_ADD));
        tbl.push_back(mk("nop_f",   I_NOP,  1'b0, F, ALU_NOP));
        tbl.push_back(mk("nop_d",   I_NOP,  1'b0, D, ALU_NOP));
        tbl.push_back(mk("nop_e",   I_NOP,  1'b0, B_OUT | B_PC, ALU_NOP));
        tbl.push_back(mk("ill_f",   I_ILL,  1'b0, F, ALU_NOP));
        tbl.push_back(mk("ill_d",   I_ILL,  1'b0, D, ALU_NOP));

        @(negedge clk);
        @(negedge clk);
        check("reset_en",  32'(en_act),     32'd0);
        check("reset_alu", 32'(alu_opcode), 32'(ALU_NOP));
        check("reset_cnt", 32'(instr_cnt),  32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_row(tbl[i]);

        for (int i = 0; i < 100; i++) begin
            run_row(mk("halt", I_ILL, 1'($urandom_range(0, 1)), B_HALT, ALU_NOP));
        end
        check("halt_cnt_frozen", 32'(instr_cnt), 32'd12);
        async_reset("halt_rst");

        run_row(mk("pre_nop_f", I_NOP, 1'b0, F, ALU_NOP));
        run_row(mk("pre_nop_d", I_NOP, 1'b0, D, ALU_NOP));
        run_row(mk("pre_nop_e", I_NOP, 1'b0, B_OUT | B_PC, ALU_NOP));
        run_row(mk("swr_f",  I_SW, 1'b0, F, ALU_NOP));
        run_row(mk("swr_d",  I_SW, 1'b0, D, ALU_NOP));
        run_row(mk("swr_e",  I_SW, 1'b0, B_MA | B_MB | B_OUT, ALU_ADD));
        run_row(mk("swr_m0", I_SW, 1'b0, B_REQ | B_WE, ALU_NOP));
        run_row(mk("swr_m1", I_SW, 1'b0, B_REQ | B_WE, ALU_NOP));
        check("swr_cnt_before", 32'(instr_cnt), 32'd1);
        async_reset("swr_midmem_rst");

        for (int i = 0; i < 16; i++) begin
            run_row(mk("wrap_f", I_NOP, 1'b1, F, ALU_NOP));
            run_row(mk("wrap_d", I_NOP, 1'b1, D, ALU_NOP));
            run_row(mk("wrap_e", I_NOP, 1'b1, B_OUT | B_PC, ALU_NOP));
        end
        run_row(mk("badf_f", I_BADF, 1'b0, F, ALU_NOP));
        check("cnt_wrap", 32'(instr_cnt), 32'd0);
        run_row(mk("badf_d", I_BADF, 1'b0, D, ALU_NOP));
        for (int i = 0; i < 3; i++) begin
            run_row(mk("badf_halt", I_BADF, 1'b1, B_HALT, ALU_NOP));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
